// File: rtl/fetch_unit.sv
// fetch_unit: VR16 instruction-fetch front end (program counter, return stack, instruction ROM).
// Latency: counter_reg updates every edge; instruction lags counter_reg by one cycle.
// Backpressure: none on the PC; imem_enable=0 freezes instruction while the PC keeps advancing.
//
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   jump_enable, jump_address   load PC with target, push counter_reg+1 on the return stack
//   return_enable               pop return stack into PC (ignored when empty or when jumping)
//   imem_enable                 instruction ROM read enable
//   counter_reg                 current program counter
//   instruction                 registered ROM word addressed by the previous counter_reg
//   stack_full, stack_empty     return-stack occupancy flags
module fetch_unit #(
  parameter int IMEM_DEPTH  = 256,
  parameter int STACK_DEPTH = 8,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump_enable,
  input  logic [15:0] jump_address,
  input  logic        return_enable,
  input  logic        imem_enable,
  output logic [15:0] counter_reg,
  output logic [15:0] instruction,
  output logic        stack_full,
  output logic        stack_empty
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int SW = $clog2(STACK_DEPTH);
  // Pointer is one bit wider than the index so it can represent STACK_DEPTH (full).
  localparam logic [SW:0] SP_FULL = (SW+1)'(STACK_DEPTH);

  logic [15:0] mem   [IMEM_DEPTH];
  logic [15:0] stack [STACK_DEPTH];
  logic [SW:0] sp;
  logic [SW:0] sp_dec;
  logic [15:0] pc_inc;
  logic        do_push;
  logic        do_pop;

  // ROM contents start at zero.
  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = 16'h0000;
  end

  assign pc_inc      = counter_reg + 16'd1;
  assign sp_dec      = sp - 1'b1;
  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == SP_FULL);

  // A jump always wins over a simultaneous return; a push into a full stack is dropped.
  assign do_push = jump_enable && !stack_full;
  assign do_pop  = !jump_enable && return_enable && !stack_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_reg <= 16'h0000;
      instruction <= 16'h0000;
      sp          <= '0;
    end else begin
      // Upper PC bits are ignored, so addresses alias modulo IMEM_DEPTH.
      if (imem_enable) instruction <= mem[counter_reg[AW-1:0]];

      if (jump_enable) begin
        counter_reg <= jump_address;
        if (do_push) sp <= sp + 1'b1;
      end else if (do_pop) begin
        counter_reg <= stack[sp_dec[SW-1:0]];
        sp          <= sp_dec;
      end else begin
        counter_reg <= pc_inc;
      end
    end
  end

  // Stack storage has no reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (!reset && do_push) stack[sp[SW-1:0]] <= pc_inc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        jump_enable = 1'b0;
  logic [15:0] jump_address = 16'h0000;
  logic        return_enable = 1'b0;
  logic        imem_enable = 1'b1;
  logic [15:0] counter_reg;
  logic [15:0] instruction;
  logic        stack_full;
  logic        stack_empty;

  always #5 clk = ~clk;

  fetch_unit #(
    .IMEM_DEPTH (256),
    .STACK_DEPTH(8),
    .INIT_FILE  ("")
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .jump_enable  (jump_enable),
    .jump_address (jump_address),
    .return_enable(return_enable),
    .imem_enable  (imem_enable),
    .counter_reg  (counter_reg),
    .instruction  (instruction),
    .stack_full   (stack_full),
    .stack_empty  (stack_empty)
  );

  typedef struct {
    logic        rst;
    logic        jmp;
    logic [15:0] addr;
    logic        ret;
    logic        en;
    logic [15:0] pc;
    logic [15:0] ins;
    logic        emp;
    logic        ful;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[13];
  int   n_vec = 0;
  int   n_err = 0;
  int   step_no = 0;

  function automatic vec_t mk(logic rst, logic jmp, logic [15:0] addr, logic ret, logic en,
                              logic [15:0] pc, logic [15:0] ins, logic emp, logic ful);
    vec_t v;
    v.rst = rst; v.jmp = jmp; v.addr = addr; v.ret = ret; v.en = en;
    v.pc = pc; v.ins = ins; v.emp = emp; v.ful = ful;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at step %0d: got %h, expected %h", nm, step_no, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    reset = v.rst; jump_enable = v.jmp; jump_address = v.addr;
    return_enable = v.ret; imem_enable = v.en;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    step_no++;
    n_vec++;
    chk("counter_reg", counter_reg, e.pc);
    chk("instruction", instruction, e.ins);
    chk("stack_empty", {15'd0, stack_empty}, {15'd0, e.emp});
    chk("stack_full",  {15'd0, stack_full},  {15'd0, e.ful});
  endtask

  initial begin
    logic [15:0] prev;
    logic [15:0] exp_pc;

    // Preload ROM with mem[i] = A000 + i before the first clock edge.
    #1;
    for (int i = 0; i < 256; i++) dut.mem[i] = 16'hA000 + 16'(i);

    //            rst  jmp  addr     ret  en    pc       ins      emp  ful
    tbl[0]  = mk(1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0001,16'hA000,1'b1,1'b0);
    tbl[1]  = mk(1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0002,16'hA001,1'b1,1'b0);
    tbl[2]  = mk(1'b0,1'b1,16'h0004,1'b0,1'b1,16'h0004,16'hA002,1'b0,1'b0);
    tbl[3]  = mk(1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0005,16'hA004,1'b0,1'b0);
    tbl[4]  = mk(1'b0,1'b0,16'h0000,1'b1,1'b1,16'h0003,16'hA005,1'b1,1'b0);
    tbl[5]  = mk(1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0004,16'hA003,1'b1,1'b0);
    tbl[6]  = mk(1'b0,1'b1,16'h0010,1'b1,1'b1,16'h0010,16'hA004,1'b0,1'b0);
    tbl[7]  = mk(1'b0,1'b0,16'h0000,1'b1,1'b1,16'h0005,16'hA010,1'b1,1'b0);
    tbl[8]  = mk(1'b0,1'b0,16'h0000,1'b1,1'b1,16'h0006,16'hA005,1'b1,1'b0);
    tbl[9]  = mk(1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0007,16'hA005,1'b1,1'b0);
    tbl[10] = mk(1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0008,16'hA005,1'b1,1'b0);
    tbl[11] = mk(1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0009,16'hA005,1'b1,1'b0);
    tbl[12] = mk(1'b0,1'b0,16'h0000,1'b0,1'b1,16'h000A,16'hA009,1'b1,1'b0);

    // Two reset cycles.
    step(mk(1'b1,1'b0,16'h0000,1'b0,1'b1,16'h0000,16'h0000,1'b1,1'b0));
    step(mk(1'b1,1'b0,16'h0000,1'b0,1'b1,16'h0000,16'h0000,1'b1,1'b0));

    for (int i = 0; i < 13; i++) step(tbl[i]);

    // Nine nested jumps from PC=000A: eight pushes fill the stack, the ninth is dropped.
    prev = 16'h000A;
    for (int k = 0; k < 9; k++) begin
      exp_pc = 16'h0020 + 16'(k);
      step(mk(1'b0,1'b1,exp_pc,1'b0,1'b1,exp_pc,16'hA000 + {8'h00, prev[7:0]},1'b0,(k >= 7)));
      prev = exp_pc;
    end

    // Unwind: 0027 down to 0021, then the first return address 000B.
    for (int r = 0; r < 8; r++) begin
      exp_pc = (r == 7) ? 16'h000B : 16'h0027 - 16'(r);
      step(mk(1'b0,1'b0,16'h0000,1'b1,1'b1,exp_pc,16'hA000 + {8'h00, prev[7:0]},(r == 7),1'b0));
      prev = exp_pc;
    end

    // Return on empty stack just increments.
    step(mk(1'b0,1'b0,16'h0000,1'b1,1'b1,16'h000C,16'hA00B,1'b1,1'b0));

    // PC wrap from FFFF, then address aliasing at 0100.
    step(mk(1'b0,1'b1,16'hFFFF,1'b0,1'b1,16'hFFFF,16'hA00C,1'b0,1'b0));
    step(mk(1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0000,16'hA0FF,1'b0,1'b0));
    step(mk(1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0001,16'hA000,1'b0,1'b0));
    step(mk(1'b0,1'b1,16'h0100,1'b0,1'b1,16'h0100,16'hA001,1'b0,1'b0));
    step(mk(1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0101,16'hA000,1'b0,1'b0));

    // Reset mid-run clears PC, instruction and stack pointer.
    step(mk(1'b1,1'b1,16'h1234,1'b1,1'b1,16'h0000,16'h0000,1'b1,1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
